// File: rtl/bp_vc_pkg.sv
// rtl/bp_vc_pkg.sv - shared types and constants for the victim cache writeback queue
package bp_vc_pkg;

    localparam int unsigned BP_VC_BLOCK_WIDTH = 512;
    localparam int unsigned BP_VC_TAG_WIDTH   = 28;
    localparam int unsigned BP_VC_STAT_WIDTH  = 2;

    localparam logic [BP_VC_STAT_WIDTH-1:0] BP_VC_STAT_CLEAN = '0;

    typedef struct packed {
        logic [BP_VC_BLOCK_WIDTH-1:0] block;
        logic [BP_VC_TAG_WIDTH-1:0]   tag;
        logic [BP_VC_STAT_WIDTH-1:0]  stat;
    } bp_vc_wb_entry_s;

endpackage

// File: rtl/bp_vc_wbq_match.sv
// rtl/bp_vc_wbq_match.sv - newest-first tag match over the valid writeback queue entries
module bp_vc_wbq_match
    import bp_vc_pkg::*;
#(
    parameter int unsigned num_entries = 4,
    parameter int unsigned tag_width   = BP_VC_TAG_WIDTH,
    parameter type         entry_t     = bp_vc_wb_entry_s,
    localparam int unsigned ptr_w      = $clog2(num_entries)
) (
    input  entry_t                 entries_i [num_entries],
    input  logic [num_entries-1:0] valid_i,
    input  logic [ptr_w-1:0]       wr_ptr_i,
    input  logic [tag_width-1:0]   tag_i,
    output logic [num_entries-1:0] hit_onehot_o,
    output entry_t                 entry_o
);

    logic             found;
    logic [ptr_w-1:0] idx;

    // Walk backwards from the slot just below the write pointer so the newest match wins.
    always_comb begin
        hit_onehot_o = '0;
        entry_o      = '0;
        found        = 1'b0;
        idx          = '0;
        for (int k = 0; k < num_entries; k++) begin
            idx = wr_ptr_i - ptr_w'(k + 1);
            if (!found && valid_i[idx] && (entries_i[idx].tag == tag_i)) begin
                found             = 1'b1;
                hit_onehot_o[idx] = 1'b1;
                entry_o           = entries_i[idx];
            end
        end
    end

endmodule

// File: rtl/bp_vc_writeback_queue.sv
// rtl/bp_vc_writeback_queue.sv - dirty-victim writeback FIFO with optional tag snoop (BP_VC_WBQ_SNOOP_EN)
module bp_vc_writeback_queue
    import bp_vc_pkg::*;
#(
    parameter int unsigned block_width = BP_VC_BLOCK_WIDTH,
    parameter int unsigned tag_width   = BP_VC_TAG_WIDTH,
    parameter int unsigned stat_width  = BP_VC_STAT_WIDTH,
    parameter int unsigned num_entries = 4
) (
    input  logic                   clk_i,
    input  logic                   reset,
    input  logic                   evict_i,
    input  logic [block_width-1:0] evict_data_i,
    input  logic [tag_width-1:0]   evict_tag_i,
    input  logic [stat_width-1:0]  evict_stat_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   overflow_o,
    output logic                   wb_v_o,
    input  logic                   wb_ready_i,
    output logic [block_width-1:0] wb_data_o,
    output logic [tag_width-1:0]   wb_tag_o,
    output logic [stat_width-1:0]  wb_stat_o,
    input  logic [tag_width-1:0]   lookup_tag_i,
    output logic                   lookup_hit_o,
    output logic [block_width-1:0] lookup_data_o,
    output logic [stat_width-1:0]  lookup_stat_o
);

    localparam int unsigned ptr_w = $clog2(num_entries);
    localparam int unsigned cnt_w = $clog2(num_entries + 1);

    typedef struct packed {
        logic [block_width-1:0] block;
        logic [tag_width-1:0]   tag;
        logic [stat_width-1:0]  stat;
    } entry_t;

    entry_t                 mem_q [num_entries];
    entry_t                 mem_d [num_entries];
    logic [num_entries-1:0] valid_q, valid_d;
    logic [ptr_w-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]       rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;

    logic enq_req, enq_ok, deq;

    assign full_o     = (count_q == cnt_w'(num_entries));
    assign empty_o    = (count_q == '0);
    assign wb_v_o     = !empty_o;
    assign overflow_o = overflow_q;
    assign wb_data_o  = mem_q[rd_ptr_q].block;
    assign wb_tag_o   = mem_q[rd_ptr_q].tag;
    assign wb_stat_o  = mem_q[rd_ptr_q].stat;

    assign enq_req = evict_i && (evict_stat_i != stat_width'(BP_VC_STAT_CLEAN));
    assign deq     = wb_v_o && wb_ready_i;
    // A full queue still accepts when the head retires in the same cycle.
    assign enq_ok  = enq_req && (!full_o || deq);

    always_comb begin
        mem_d      = mem_q;
        valid_d    = valid_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (enq_req && full_o && !deq);
        if (deq) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (enq_ok) begin
            mem_d[wr_ptr_q]   = '{block: evict_data_i, tag: evict_tag_i, stat: evict_stat_i};
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        case ({enq_ok, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            for (int i = 0; i < num_entries; i++) begin
                mem_q[i] <= '0;
            end
            valid_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef BP_VC_WBQ_SNOOP_EN
    logic [num_entries-1:0] match_onehot;
    entry_t                 match_entry;
    logic                   match_tag_unused;

    bp_vc_wbq_match #(
        .num_entries (num_entries),
        .tag_width   (tag_width),
        .entry_t     (entry_t)
    ) u_match (
        .entries_i    (mem_q),
        .valid_i      (valid_q),
        .wr_ptr_i     (wr_ptr_q),
        .tag_i        (lookup_tag_i),
        .hit_onehot_o (match_onehot),
        .entry_o      (match_entry)
    );

    assign lookup_hit_o     = |match_onehot;
    assign lookup_data_o    = match_entry.block;
    assign lookup_stat_o    = match_entry.stat;
    assign match_tag_unused = ^match_entry.tag;
`else
    logic lookup_tag_unused;

    assign lookup_hit_o      = 1'b0;
    assign lookup_data_o     = '0;
    assign lookup_stat_o     = '0;
    assign lookup_tag_unused = ^lookup_tag_i;
`endif

endmodule

// File: tb/tb_bp_vc_writeback_queue.sv
// tb/tb_bp_vc_writeback_queue.sv - directed self-checking bench for bp_vc_writeback_queue
module tb_bp_vc_writeback_queue;

    localparam int BW = 512;
    localparam int TW = 28;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          evict_i;
    logic [BW-1:0] evict_data_i;
    logic [TW-1:0] evict_tag_i;
    logic [SW-1:0] evict_stat_i;
    logic          full_o, empty_o, overflow_o, wb_v_o;
    logic          wb_ready_i;
    logic [BW-1:0] wb_data_o;
    logic [TW-1:0] wb_tag_o;
    logic [SW-1:0] wb_stat_o;
    logic [TW-1:0] lookup_tag_i;
    logic          lookup_hit_o;
    logic [BW-1:0] lookup_data_o;
    logic [SW-1:0] lookup_stat_o;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BP_VC_WBQ_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif

    bp_vc_writeback_queue #(
        .block_width (BW),
        .tag_width   (TW),
        .stat_width  (SW),
        .num_entries (4)
    ) dut (
        .clk_i         (clk),
        .reset         (rst_n),
        .evict_i       (evict_i),
        .evict_data_i  (evict_data_i),
        .evict_tag_i   (evict_tag_i),
        .evict_stat_i  (evict_stat_i),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .overflow_o    (overflow_o),
        .wb_v_o        (wb_v_o),
        .wb_ready_i    (wb_ready_i),
        .wb_data_o     (wb_data_o),
        .wb_tag_o      (wb_tag_o),
        .wb_stat_o     (wb_stat_o),
        .lookup_tag_i  (lookup_tag_i),
        .lookup_hit_o  (lookup_hit_o),
        .lookup_data_o (lookup_data_o),
        .lookup_stat_o (lookup_stat_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [TW-1:0] tag, input logic [SW-1:0] stat, input logic [BW-1:0] data);
        evict_i      = 1'b1;
        evict_tag_i  = tag;
        evict_stat_i = stat;
        evict_data_i = data;
        step();
        evict_i      = 1'b0;
    endtask

    task automatic test_reset();
        evict_i = 0; evict_data_i = '0; evict_tag_i = '0; evict_stat_i = '0;
        wb_ready_i = 0; lookup_tag_i = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n_checks++;
        if ({full_o, empty_o, overflow_o, wb_v_o, lookup_hit_o} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 01000", {full_o, empty_o, overflow_o, wb_v_o, lookup_hit_o});
        end
        n_checks++;
        if (wb_data_o !== '0 || wb_tag_o !== '0 || wb_stat_o !== '0) begin
            n_fail++;
            $display("FAIL reset_wb_fields: tag %h stat %h expected zeros", wb_tag_o, wb_stat_o);
        end
        n_checks++;
        if (lookup_data_o !== '0 || lookup_stat_o !== '0) begin
            n_fail++;
            $display("FAIL reset_lookup_fields: stat %h expected zeros", lookup_stat_o);
        end
    endtask

    task automatic test_pass_through();
        logic [BW-1:0] d;
        d = {64{8'hAA}};
        wb_ready_i   = 1'b1;
        evict_i      = 1'b1;
        evict_tag_i  = 28'h5;
        evict_stat_i = 2'd2;
        evict_data_i = d;
        n_checks++;
        if (wb_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_no_bypass: wb_v_o %b expected 0", wb_v_o);
        end
        step();
        evict_i = 1'b0;
        n_checks++;
        if (wb_v_o !== 1'b1 || wb_tag_o !== 28'h5 || wb_stat_o !== 2'd2 || wb_data_o !== d || empty_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_head: v %b tag %h stat %h empty %b expected 1 5 2 0", wb_v_o, wb_tag_o, wb_stat_o, empty_o);
        end
        step();
        n_checks++;
        if (empty_o !== 1'b1 || wb_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_retired: empty %b v %b expected 1 0", empty_o, wb_v_o);
        end
    endtask

    task automatic test_clean_discard();
        wb_ready_i = 1'b0;
        push(28'h11, 2'd0, {16{32'hDEADBEEF}});
        step();
        n_checks++;
        if (empty_o !== 1'b1 || wb_v_o !== 1'b0 || overflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_discard: empty %b v %b ovf %b expected 1 0 0", empty_o, wb_v_o, overflow_o);
        end
    endtask

    task automatic test_fill_overflow();
        logic [TW-1:0] exp_tags [4];
        exp_tags = '{28'h2, 28'h3, 28'h4, 28'h6};
        wb_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(TW'(i), 2'd1, {64{8'(8'h10 + i)}});
        end
        n_checks++;
        if (full_o !== 1'b1 || overflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: full %b ovf %b expected 1 0", full_o, overflow_o);
        end
        push(28'h5, 2'd1, {64{8'h15}});
        n_checks++;
        if (full_o !== 1'b1 || overflow_o !== 1'b1 || wb_tag_o !== 28'h1) begin
            n_fail++;
            $display("FAIL overflow_drop: full %b ovf %b head %h expected 1 1 1", full_o, overflow_o, wb_tag_o);
        end
        wb_ready_i = 1'b1;
        evict_i = 1'b1; evict_tag_i = 28'h6; evict_stat_i = 2'd3; evict_data_i = {64{8'h16}};
        n_checks++;
        if (full_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_no_lookahead: full %b expected 1", full_o);
        end
        step();
        evict_i = 1'b0;
        n_checks++;
        if (full_o !== 1'b1 || wb_tag_o !== 28'h2 || overflow_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_enq_deq: full %b head %h ovf %b expected 1 2 1", full_o, wb_tag_o, overflow_o);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wb_v_o !== 1'b1 || wb_tag_o !== exp_tags[i]) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: v %b tag %h expected 1 %h", i, wb_v_o, wb_tag_o, exp_tags[i]);
            end
            step();
        end
        n_checks++;
        if (empty_o !== 1'b1 || wb_stat_o !== 2'd1) begin
            n_fail++;
            $display("FAIL drain_empty: empty %b expected 1", empty_o);
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] d;
        d = {16{32'h1234_5678}};
        do_reset();
        wb_ready_i = 1'b0;
        push(28'h7, 2'd3, d);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (wb_v_o !== 1'b1 || wb_tag_o !== 28'h7 || wb_stat_o !== 2'd3 || wb_data_o !== d) begin
                n_fail++;
                $display("FAIL backpressure_stable[%0d]: v %b tag %h stat %h expected 1 7 3", i, wb_v_o, wb_tag_o, wb_stat_o);
            end
            step();
        end
        wb_ready_i = 1'b1;
        step();
        n_checks++;
        if (wb_v_o !== 1'b0 || empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: v %b empty %b expected 0 1", wb_v_o, empty_o);
        end
    endtask

    task automatic test_snoop();
        logic [BW-1:0] da, db, dc;
        da = {64{8'hA1}};
        db = {64{8'hB2}};
        dc = {64{8'hC3}};
        do_reset();
        wb_ready_i = 1'b0;
        push(28'h9, 2'd1, da);
        push(28'h9, 2'd2, db);
        lookup_tag_i = 28'h9;
        #1;
        n_checks++;
        if (lookup_hit_o !== SNOOP || lookup_data_o !== (SNOOP ? db : '0) || lookup_stat_o !== (SNOOP ? 2'd2 : 2'd0)) begin
            n_fail++;
            $display("FAIL snoop_newest: hit %b stat %h expected %b %h", lookup_hit_o, lookup_stat_o, SNOOP, SNOOP ? 2'd2 : 2'd0);
        end
        lookup_tag_i = 28'h3;
        #1;
        n_checks++;
        if (lookup_hit_o !== 1'b0 || lookup_data_o !== '0 || lookup_stat_o !== '0) begin
            n_fail++;
            $display("FAIL snoop_miss: hit %b stat %h expected 0 0", lookup_hit_o, lookup_stat_o);
        end
        lookup_tag_i = 28'hC;
        evict_i = 1'b1; evict_tag_i = 28'hC; evict_stat_i = 2'd1; evict_data_i = dc;
        #1;
        n_checks++;
        if (lookup_hit_o !== 1'b0) begin
            n_fail++;
            $display("FAIL snoop_same_cycle: hit %b expected 0", lookup_hit_o);
        end
        step();
        evict_i = 1'b0;
        n_checks++;
        if (lookup_hit_o !== SNOOP || lookup_data_o !== (SNOOP ? dc : '0)) begin
            n_fail++;
            $display("FAIL snoop_next_cycle: hit %b expected %b", lookup_hit_o, SNOOP);
        end
        lookup_tag_i = 28'h9;
        wb_ready_i = 1'b1;
        step();
        wb_ready_i = 1'b0;
        n_checks++;
        if (lookup_hit_o !== SNOOP || lookup_data_o !== (SNOOP ? db : '0) || wb_tag_o !== 28'h9 || wb_data_o !== db) begin
            n_fail++;
            $display("FAIL snoop_after_retire: hit %b head %h expected %b 9", lookup_hit_o, wb_tag_o, SNOOP);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        wb_ready_i = 1'b0;
        push(28'h21, 2'd1, {64{8'h21}});
        push(28'h22, 2'd2, {64{8'h22}});
        push(28'h23, 2'd3, {64{8'h23}});
        lookup_tag_i = 28'h22;
        #1;
        n_checks++;
        if (wb_v_o !== 1'b1 || lookup_hit_o !== SNOOP) begin
            n_fail++;
            $display("FAIL mid_reset_pre: v %b hit %b expected 1 %b", wb_v_o, lookup_hit_o, SNOOP);
        end
        wb_ready_i = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wb_ready_i = 1'b0;
        n_checks++;
        if (wb_v_o !== 1'b0 || empty_o !== 1'b1 || overflow_o !== 1'b0 || lookup_hit_o !== 1'b0 || wb_data_o !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_post: v %b empty %b ovf %b hit %b expected 0 1 0 0", wb_v_o, empty_o, overflow_o, lookup_hit_o);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_clean_discard();
        test_fill_overflow();
        test_backpressure();
        test_snoop();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
